// File: rtl/i2c_master_arbiter.sv
// rtl/i2c_master_arbiter.sv - round-robin arbiter sharing one i2c master_device
module i2c_master_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int LAUNCH_TIMEOUT = 64
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [NUM_REQ-1:0]   i_req,
    input  logic [7*NUM_REQ-1:0] i_addr,
    input  logic [NUM_REQ-1:0]   i_rw,
    input  logic [8*NUM_REQ-1:0] i_wdata,
    output logic [NUM_REQ-1:0]   o_gnt,
    output logic [NUM_REQ-1:0]   o_done,
    output logic [NUM_REQ-1:0]   o_err,
    output logic                 o_busy,
    output logic                 o_m_enable,
    output logic [6:0]           o_m_address,
    output logic                 o_m_rw,
    output logic [7:0]           o_m_data,
    input  logic                 i_m_busy
);

    localparam int PW = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;
    localparam int CW = (LAUNCH_TIMEOUT > 2) ? $clog2(LAUNCH_TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_RUN    = 3'd2,
        S_DONE   = 3'd3,
        S_ERR    = 3'd4
    } state_t;

    state_t             r_state, w_state_nxt;
    logic               r_busy_s1, r_busy_s2;
    logic [PW-1:0]      r_ptr, w_ptr_nxt;
    logic [PW-1:0]      r_gidx, w_gidx_nxt;
    logic [PW-1:0]      w_win;
    logic               w_found;
    logic [CW-1:0]      r_cnt, w_cnt_nxt;
    logic [NUM_REQ-1:0] r_gnt, w_gnt_nxt;
    logic               r_en, w_en_nxt;
    logic [6:0]         r_addr, w_addr_nxt;
    logic               r_rw, w_rw_nxt;
    logic [7:0]         r_data, w_data_nxt;

    // Two-flop synchroniser: master busy is launched from the divided SCL domain
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_busy_s1 <= 1'b0;
            r_busy_s2 <= 1'b0;
        end else begin
            r_busy_s1 <= i_m_busy;
            r_busy_s2 <= r_busy_s1;
        end
    end

    // Round-robin search: first requester after the last one served, with wrap-around
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (!w_found && i_req[(int'(r_ptr) + i) % NUM_REQ]) begin
                w_found = 1'b1;
                w_win   = PW'((int'(r_ptr) + i) % NUM_REQ);
            end
        end
    end

    // State and datapath registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_ptr   <= PW'(NUM_REQ - 1);
            r_gidx  <= '0;
            r_cnt   <= '0;
            r_gnt   <= '0;
            r_en    <= 1'b0;
            r_addr  <= '0;
            r_rw    <= 1'b0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_gidx  <= w_gidx_nxt;
            r_cnt   <= w_cnt_nxt;
            r_gnt   <= w_gnt_nxt;
            r_en    <= w_en_nxt;
            r_addr  <= w_addr_nxt;
            r_rw    <= w_rw_nxt;
            r_data  <= w_data_nxt;
        end
    end

    // Next-state logic: grant in IDLE, wait for busy in LAUNCH, wait for idle in RUN
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_gidx_nxt  = r_gidx;
        w_cnt_nxt   = r_cnt;
        w_gnt_nxt   = r_gnt;
        w_en_nxt    = r_en;
        w_addr_nxt  = r_addr;
        w_rw_nxt    = r_rw;
        w_data_nxt  = r_data;
        case (r_state)
            S_IDLE: begin
                // Foreign bus activity blocks new grants but is otherwise ignored
                if (w_found && !r_busy_s2) begin
                    w_gnt_nxt        = '0;
                    w_gnt_nxt[w_win] = 1'b1;
                    w_gidx_nxt       = w_win;
                    w_addr_nxt       = i_addr[7*int'(w_win) +: 7];
                    w_rw_nxt         = i_rw[w_win];
                    w_data_nxt       = i_wdata[8*int'(w_win) +: 8];
                    w_en_nxt         = 1'b1;
                    w_cnt_nxt        = '0;
                    w_state_nxt      = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                w_cnt_nxt = r_cnt + CW'(1);
                if (r_busy_s2) begin
                    w_en_nxt    = 1'b0;
                    w_state_nxt = S_RUN;
                end else if (r_cnt == CW'(LAUNCH_TIMEOUT - 1)) begin
                    w_en_nxt    = 1'b0;
                    w_state_nxt = S_ERR;
                end
            end
            S_RUN: begin
                if (!r_busy_s2) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE, S_ERR: begin
                w_gnt_nxt   = '0;
                w_ptr_nxt   = r_gidx;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_gnt_nxt   = '0;
                w_en_nxt    = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign o_gnt       = r_gnt;
    assign o_done      = (r_state == S_DONE) ? r_gnt : '0;
    assign o_err       = (r_state == S_ERR) ? r_gnt : '0;
    assign o_busy      = (r_state != S_IDLE);
    assign o_m_enable  = r_en;
    assign o_m_address = r_addr;
    assign o_m_rw      = r_rw;
    assign o_m_data    = r_data;

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// tb/tb_i2c_master_arbiter.sv - scoreboard bench for i2c_master_arbiter
module tb_i2c_master_arbiter;

    localparam int N = 4;
    localparam int T = 64;

    typedef struct {
        logic [3:0] gnt;
        logic       done;
        logic [6:0] addr;
        logic       rw;
        logic [7:0] data;
    } exp_t;

    typedef struct {
        bit never;
        int dly;
        int hold;
    } mode_t;

    logic        clk;
    logic        rst_n;
    logic [3:0]  i_req;
    logic [27:0] i_addr;
    logic [3:0]  i_rw;
    logic [31:0] i_wdata;
    logic [3:0]  o_gnt, o_done, o_err;
    logic        o_busy, o_m_enable, o_m_rw;
    logic [6:0]  o_m_address;
    logic [7:0]  o_m_data;
    logic        m_busy_model, m_busy_foreign;
    logic        i_m_busy;

    assign i_m_busy = m_busy_model | m_busy_foreign;

    int n_chk  = 0;
    int n_pass = 0;
    int model_ptr = N - 1;
    exp_t  exp_q[$];
    mode_t mq[$];
    logic [6:0] sh_addr[N];
    logic       sh_rw[N];
    logic [7:0] sh_data[N];

    i2c_master_arbiter #(.NUM_REQ(N), .LAUNCH_TIMEOUT(T)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(i_req), .i_addr(i_addr),
        .i_rw(i_rw), .i_wdata(i_wdata), .o_gnt(o_gnt), .o_done(o_done),
        .o_err(o_err), .o_busy(o_busy), .o_m_enable(o_m_enable),
        .o_m_address(o_m_address), .o_m_rw(o_m_rw), .o_m_data(o_m_data),
        .i_m_busy(i_m_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    task automatic pack();
        for (int k = 0; k < N; k++) begin
            i_addr[7*k +: 7]  = sh_addr[k];
            i_rw[k]           = sh_rw[k];
            i_wdata[8*k +: 8] = sh_data[k];
        end
    endtask

    task automatic set_fields();
        for (int k = 0; k < N; k++) begin
            sh_addr[k] = 7'($urandom);
            sh_rw[k]   = 1'($urandom);
            sh_data[k] = 8'($urandom);
        end
        pack();
    endtask

    // Reference model: each holder of a request is served in cyclic order after the last one served
    task automatic launch(input logic [3:0] mask, input int n, input int never8,
                          input int dly, input int hold);
        int p;
        int k;
        exp_t e;
        mode_t m;
        p = model_ptr;
        for (int t = 0; t < n; t++) begin
            k = p;
            for (int i = 1; i <= N; i++) begin
                if (mask[(p + i) % N]) begin
                    k = (p + i) % N;
                    break;
                end
            end
            m.never = (int'($urandom_range(0, 7)) < never8);
            m.dly   = (dly < 0) ? int'($urandom_range(0, 5)) : dly;
            m.hold  = (hold < 0) ? int'($urandom_range(1, 12)) : hold;
            e.gnt   = 4'b0001 << k;
            e.done  = !m.never;
            e.addr  = sh_addr[k];
            e.rw    = sh_rw[k];
            e.data  = sh_data[k];
            exp_q.push_back(e);
            mq.push_back(m);
            p = k;
        end
        model_ptr = p;
        i_req = mask;
    endtask

    task automatic wait_done(input int n);
        int cnt;
        int cyc;
        cnt = 0;
        cyc = 0;
        while (cnt < n && cyc < 3000) begin
            @(posedge clk); #1;
            cyc++;
            if ((o_done | o_err) != 4'b0) cnt++;
        end
        i_req = 4'b0;
        if (cnt < n) chk("wait_done_timeout", 32'(cnt), 32'(n));
    endtask

    // Monitor: compare each new grant and each done/err pulse against the scoreboard head
    initial begin
        logic [3:0] prev_gnt;
        exp_t e;
        prev_gnt = 4'b0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                prev_gnt = 4'b0;
                continue;
            end
            if (o_gnt != 4'b0 && o_gnt != prev_gnt) begin
                if (exp_q.size() == 0) chk("gnt_unexpected", 32'(o_gnt), 32'(0));
                else chk("gnt", 32'(o_gnt), 32'(exp_q[0].gnt));
            end
            if ((o_done | o_err) != 4'b0) begin
                if (exp_q.size() == 0) begin
                    chk("pulse_unexpected", 32'(o_done | o_err), 32'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk("done_vec", 32'(o_done), e.done ? 32'(e.gnt) : 32'(0));
                    chk("err_vec", 32'(o_err), e.done ? 32'(0) : 32'(e.gnt));
                    chk("m_address", 32'(o_m_address), 32'(e.addr));
                    chk("m_rw", 32'(o_m_rw), 32'(e.rw));
                    chk("m_data", 32'(o_m_data), 32'(e.data));
                end
            end
            prev_gnt = o_gnt;
        end
    end

    // Master device model: answers each enable with a busy pulse, or stays silent
    initial begin
        logic prev_en;
        mode_t m;
        int cnt;
        int last;
        prev_en = 1'b0;
        m_busy_model = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (rst_n && o_m_enable && !prev_en) begin
                if (mq.size() == 0) begin
                    chk("mode_missing", 32'(mq.size()), 32'(1));
                    m.never = 1'b0; m.dly = 1; m.hold = 3;
                end else begin
                    m = mq.pop_front();
                end
                if (m.never) begin
                    cnt = 1;
                    while (o_m_enable && rst_n && cnt < 200) begin
                        @(posedge clk); #1;
                        if (o_m_enable) cnt++;
                    end
                    chk("en_width", 32'(cnt), 32'(T));
                end else begin
                    repeat (m.dly) begin @(posedge clk); #1; end
                    m_busy_model = 1'b1;
                    last = (m.hold > 3) ? m.hold : 3;
                    for (int c = 1; c <= last; c++) begin
                        @(posedge clk); #1;
                        if (!rst_n) break;
                        if (c == 2) chk("en_hold", 32'(o_m_enable), 32'(1));
                        if (c == 3) chk("en_drop", 32'(o_m_enable), 32'(0));
                        if (c == m.hold) m_busy_model = 1'b0;
                    end
                    m_busy_model = 1'b0;
                end
            end
            prev_en = rst_n ? o_m_enable : 1'b0;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        logic [6:0] cap;
        rst_n = 1'b0;
        i_req = 4'b0;
        m_busy_foreign = 1'b0;
        for (int k = 0; k < N; k++) begin
            sh_addr[k] = '0; sh_rw[k] = 1'b0; sh_data[k] = '0;
        end
        pack();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {o_gnt, o_done, o_err, o_busy, o_m_enable, o_m_rw, o_m_address, o_m_data},
            32'(0));
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Round robin from reset: 0,1,2,3,0
        set_fields();
        launch(4'b1111, 5, 0, -1, -1);
        wait_done(5);
        @(posedge clk); #1;

        // Single write to requester 1
        set_fields();
        sh_addr[1] = 7'h50; sh_rw[1] = 1'b0; sh_data[1] = 8'hA5;
        pack();
        launch(4'b0010, 1, 0, 6, 40);
        @(posedge clk); #1;
        chk("t1_gnt", 32'(o_gnt), 32'h2);
        chk("t1_enable", 32'(o_m_enable), 32'h1);
        chk("t1_addr", 32'(o_m_address), 32'h50);
        wait_done(1);
        @(posedge clk); #1;

        // Launch timeout on requester 2
        launch(4'b0100, 1, 8, 0, 0);
        wait_done(1);
        @(posedge clk); #1;
        chk("t3_idle", 32'(o_busy), 32'(0));

        // Field capture and request drop during RUN
        set_fields();
        launch(4'b0001, 1, 0, 2, 30);
        cap = sh_addr[0];
        cyc = 0;
        while (!o_m_enable && cyc < 100) begin @(posedge clk); #1; cyc++; end
        while (o_m_enable && cyc < 200) begin @(posedge clk); #1; cyc++; end
        chk("t4_in_run", 32'(o_busy && !o_m_enable), 32'(1));
        i_addr[6:0] = ~cap;
        i_req = 4'b0;
        @(posedge clk); #1;
        chk("t4_addr_held", 32'(o_m_address), 32'(cap));
        wait_done(1);
        pack();
        @(posedge clk); #1;

        // Foreign busy in IDLE blocks the grant
        m_busy_foreign = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        launch(4'b0001, 1, 0, 1, 5);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("t6_no_gnt", 32'(o_gnt), 32'(0));
        end
        m_busy_foreign = 1'b0;
        @(posedge clk); #1;
        chk("t6_gnt_f1", 32'(o_gnt), 32'(0));
        @(posedge clk); #1;
        chk("t6_gnt_f2", 32'(o_gnt), 32'(0));
        @(posedge clk); #1;
        chk("t6_gnt_f3", 32'(o_gnt), 32'h1);
        wait_done(1);
        @(posedge clk); #1;

        // Randomised rounds with held request masks
        for (int r = 0; r < 15; r++) begin
            logic [3:0] mask;
            int n;
            set_fields();
            mask = 4'($urandom_range(1, 15));
            n = $countones(mask) * int'($urandom_range(1, 2));
            launch(mask, n, 1, -1, -1);
            wait_done(n);
            @(posedge clk); #1;
        end

        // Reset in the middle of RUN
        set_fields();
        launch(4'b0010, 1, 0, 2, 40);
        cyc = 0;
        while (!o_m_enable && cyc < 100) begin @(posedge clk); #1; cyc++; end
        while (o_m_enable && cyc < 200) begin @(posedge clk); #1; cyc++; end
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        exp_q.delete();
        i_req = 4'b0;
        #1;
        chk("t5_async_zero", {o_gnt, o_done, o_err, o_busy, o_m_enable, o_m_rw, o_m_address, o_m_data},
            32'(0));
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("t5_no_done", 32'(o_done | o_err), 32'(0));
        end
        @(negedge clk) rst_n = 1'b1;
        model_ptr = N - 1;
        @(posedge clk); #1;
        launch(4'b1000, 1, 0, 1, 4);
        @(posedge clk); #1;
        chk("t5_regrant", 32'(o_gnt), 32'h8);
        wait_done(1);
        repeat (3) @(posedge clk);
        #1;

        chk("scoreboard_empty", 32'(exp_q.size()), 32'(0));
        chk("modes_empty", 32'(mq.size()), 32'(0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
